// File: rtl/apb_bus_bridge_if.sv
// Signal bundle between the CPU load/store port, the bridge and the APB slaves.
// The bridge uses the master view; the environment (core + slaves) uses the slave view.
interface apb_bus_bridge_if #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned REGION_BITS = 12
);
  logic                         busReq;
  logic                         busWe;
  logic [2:0]                   strb;
  logic [31:0]                  busAddr;
  logic [31:0]                  busWData;
  logic [31:0]                  busRData;
  logic                         busReady;
  logic                         busErr;
  logic [NUM_SLAVES-1:0]        psel;
  logic                         penable;
  logic                         pwrite;
  logic [REGION_BITS-1:0]       paddr;
  logic [31:0]                  pwdata;
  logic [3:0]                   pstrb;
  logic [32*NUM_SLAVES-1:0]     prdata;
  logic [NUM_SLAVES-1:0]        pready;
  logic [NUM_SLAVES-1:0]        pslverr;

  modport master (
    input  busReq, busWe, strb, busAddr, busWData, prdata, pready, pslverr,
    output busRData, busReady, busErr, psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output busReq, busWe, strb, busAddr, busWData, prdata, pready, pslverr,
    input  busRData, busReady, busErr, psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_bus_bridge.sv
// Single-outstanding bridge from the core's load/store port to NUM_SLAVES APB peripherals,
// with lane strobes, decode/misalignment checks and an ACCESS-phase timeout.
module apb_bus_bridge #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned REGION_BITS = 12,
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic              clk,
  input logic              reset,
  apb_bus_bridge_if.master bus
);

  localparam int unsigned IdxW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [7:0]             cnt_q, cnt_d, cnt_inc;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [REGION_BITS-1:0] paddr_q, paddr_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic [3:0]             pstrb_q, pstrb_d;
  logic                   ready_q, ready_d;
  logic                   berr_q, berr_d;
  logic [31:0]            brdata_q, brdata_d;

  // Request decode, evaluated combinationally on the live request in IDLE.
  logic [31:0]     req_off, req_region, lane_data;
  logic            req_miss, req_misalign, req_bad;
  logic [IdxW-1:0] req_idx;
  logic [3:0]      lane_strb;

  assign req_off    = bus.busAddr - BASE_ADDR;
  assign req_region = req_off >> REGION_BITS;
  assign req_miss   = (bus.busAddr < BASE_ADDR) || (req_region >= NUM_SLAVES);
  assign req_idx    = req_region[IdxW-1:0];
  assign req_bad    = req_miss || req_misalign;
  assign lane_data  = bus.busWData << {bus.busAddr[1:0], 3'b000};

  always_comb begin
    case (bus.strb[1:0])
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = bus.busAddr[0];
      2'b10:   req_misalign = |bus.busAddr[1:0];
      default: req_misalign = 1'b1;
    endcase
  end

  always_comb begin
    case (bus.strb[1:0])
      2'b00:   lane_strb = 4'b0001 << bus.busAddr[1:0];
      2'b01:   lane_strb = 4'b0011 << bus.busAddr[1:0];
      default: lane_strb = 4'b1111;
    endcase
  end

  // Only the addressed slave's handshake is ever looked at.
  logic        sel_ready, sel_err;
  logic [31:0] sel_rdata;

  assign sel_ready = bus.pready[idx_q];
  assign sel_err   = bus.pslverr[idx_q];
  assign sel_rdata = bus.prdata[32*idx_q +: 32];
  assign cnt_inc   = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rdata_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ready_q   <= 1'b0;
      berr_q    <= 1'b0;
      brdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ready_q   <= ready_d;
      berr_q    <= berr_d;
      brdata_q  <= brdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.busReq) state_d = req_bad ? StResp : StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (sel_ready || (cnt_inc == TimeoutCnt)) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    we_d     = we_q;
    err_d    = err_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.busReq) begin
          we_d    = bus.busWe;
          err_d   = req_bad;
          idx_d   = req_idx;
          rdata_d = '0;
          // Rejected requests never reach the APB side, so its outputs stay put.
          if (!req_bad) begin
            pwrite_d = bus.busWe;
            paddr_d  = {req_off[REGION_BITS-1:2], 2'b00};
            pwdata_d = bus.busWe ? lane_data : '0;
            pstrb_d  = bus.busWe ? lane_strb : 4'b0000;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_inc;
        if (sel_ready) begin
          err_d = sel_err;
          if (!we_q) rdata_d = sel_rdata;
        end else if (cnt_inc == TimeoutCnt) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    psel_d    = '0;
    if ((state_d == StSetup) || (state_d == StAccess)) psel_d = NUM_SLAVES'(1) << idx_d;
    penable_d = (state_d == StAccess);

    ready_d  = (state_q == StResp);
    berr_d   = (state_q == StResp) && err_q;
    brdata_d = '0;
    if (state_q == StResp) brdata_d = err_q ? ERR_DATA : (we_q ? 32'h0 : rdata_q);
  end

  assign bus.psel     = psel_q;
  assign bus.penable  = penable_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.pstrb    = pstrb_q;
  assign bus.busReady = ready_q;
  assign bus.busErr   = berr_q;
  assign bus.busRData = brdata_q;

endmodule

// File: tb/tb_apb_bus_bridge.sv
// Bench for apb_bus_bridge: directed cases then random transfers, each checked cycle by cycle
// against a timeline/response model derived from address, size and slave wait behaviour.
module tb_apb_bus_bridge;

  localparam int unsigned NUM_SLAVES  = 4;
  localparam int unsigned REGION_BITS = 12;
  localparam int unsigned TIMEOUT     = 16;
  localparam logic [31:0] BASE_ADDR   = 32'h1000_0000;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] slave_word [NUM_SLAVES];

  apb_bus_bridge_if #(.NUM_SLAVES(NUM_SLAVES), .REGION_BITS(REGION_BITS)) bus ();

  apb_bus_bridge #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_BITS(REGION_BITS),
    .TIMEOUT    (TIMEOUT),
    .ERR_DATA   (ERR_DATA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Selected slave answers as told; every other slave toggles noise that must be ignored.
  task automatic drive_slaves(input int idx, input bit sel_valid, input bit rdy, input bit serr);
    for (int s = 0; s < NUM_SLAVES; s++) begin
      bus.prdata[32*s +: 32] = slave_word[s];
      if (sel_valid && s == idx) begin
        bus.pready[s]  = rdy;
        bus.pslverr[s] = rdy ? serr : 1'($urandom);
      end else begin
        bus.pready[s]  = 1'($urandom);
        bus.pslverr[s] = 1'($urandom);
      end
    end
  endtask

  task automatic new_words();
    for (int s = 0; s < NUM_SLAVES; s++) slave_word[s] = $urandom;
  endtask

  // waits = ACCESS cycles before pready; pready rises on ACCESS cycle waits+1.
  task automatic txn(input logic [31:0] addr, input bit we, input logic [2:0] sz,
                     input logic [31:0] wd, input int waits, input bit serr);
    int unsigned bytes, region, idx, lat;
    bit bad, tmo, err, active;
    logic [31:0] off, exp_rdata, exp_pwdata;
    logic [3:0] exp_pstrb;
    logic [REGION_BITS-1:0] exp_paddr;
    logic [NUM_SLAVES-1:0] onehot;

    bytes  = 1 << sz[1:0];
    off    = addr - BASE_ADDR;
    region = off / (1 << REGION_BITS);
    bad    = (sz[1:0] == 2'b11) || (addr % bytes != 0) || (addr < BASE_ADDR) ||
             (region >= NUM_SLAVES);
    idx    = bad ? 0 : region;
    tmo    = !bad && (waits >= TIMEOUT);
    err    = bad || tmo || serr;
    lat    = bad ? 1 : (tmo ? TIMEOUT + 2 : waits + 3);
    onehot = '0;
    if (!bad) onehot[idx] = 1'b1;
    exp_paddr  = REGION_BITS'((off % (1 << REGION_BITS)) / 4 * 4);
    exp_pstrb  = we ? 4'(((1 << bytes) - 1) << (addr % 4)) : 4'b0000;
    exp_pwdata = wd << (8 * (addr % 4));
    exp_rdata  = err ? ERR_DATA : (we ? 32'h0 : slave_word[idx]);

    bus.busReq   = 1'b1;
    bus.busWe    = we;
    bus.strb     = sz;
    bus.busAddr  = addr;
    bus.busWData = wd;
    drive_slaves(idx, !bad, 1'b0, 1'b0);

    for (int e = 0; e <= int'(lat); e++) begin
      @(posedge clk);
      #1;
      active = !bad && (e <= int'(lat) - 2);
      check("psel", bus.psel, active ? onehot : '0);
      check("penable", bus.penable, !bad && e >= 1 && e <= int'(lat) - 2);
      check("busReady", bus.busReady, e == int'(lat));
      if (active) begin
        check("paddr", bus.paddr, exp_paddr);
        check("pwrite", bus.pwrite, we);
        check("pstrb", bus.pstrb, exp_pstrb);
        if (we) check("pwdata", bus.pwdata, exp_pwdata);
      end
      if (e == int'(lat)) begin
        check("busErr", bus.busErr, err);
        check("busRData", bus.busRData, exp_rdata);
        bus.busReq = 1'b0;
      end
      drive_slaves(idx, !bad, (e + 1) == waits + 2, serr);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_busReady", bus.busReady, 1'b0);
      check("idle_psel", bus.psel, '0);
    end
  endtask

  initial begin
    logic [31:0] addr;
    int r, waits;

    bus.busReq   = 1'b0;
    bus.busWe    = 1'b0;
    bus.strb     = 3'b010;
    bus.busAddr  = '0;
    bus.busWData = '0;
    bus.prdata   = '0;
    bus.pready   = '0;
    bus.pslverr  = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", bus.psel, '0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_pwrite", bus.pwrite, 1'b0);
    check("rst_paddr", bus.paddr, '0);
    check("rst_pwdata", bus.pwdata, '0);
    check("rst_pstrb", bus.pstrb, '0);
    check("rst_busReady", bus.busReady, 1'b0);
    check("rst_busErr", bus.busErr, 1'b0);
    check("rst_busRData", bus.busRData, '0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    new_words();
    slave_word[2] = 32'h1234_5678;
    txn(32'h1000_2008, 1'b0, 3'b010, 32'h0, 2, 1'b0);
    txn(32'h1000_0003, 1'b1, 3'b000, 32'h0000_00AB, 0, 1'b0);
    txn(32'h1000_1002, 1'b1, 3'b001, 32'h0000_BEEF, 1, 1'b0);
    txn(32'h1000_0002, 1'b1, 3'b010, 32'h1111_2222, 0, 1'b0);
    txn(32'h1000_4000, 1'b0, 3'b010, 32'h0, 0, 1'b0);
    txn(32'h0FFF_FFFC, 1'b0, 3'b010, 32'h0, 0, 1'b0);
    txn(32'h1000_0001, 1'b0, 3'b011, 32'h0, 0, 1'b0);
    txn(32'h1000_3010, 1'b0, 3'b010, 32'h0, 1000, 1'b0);
    txn(32'h1000_3014, 1'b0, 3'b010, 32'h0, TIMEOUT - 1, 1'b0);
    txn(32'h1000_1004, 1'b0, 3'b010, 32'h0, 0, 1'b1);
    // Held request: consecutive zero-wait transfers with no idle gap.
    txn(32'h1000_0100, 1'b1, 3'b010, 32'hCAFE_F00D, 0, 1'b0);
    txn(32'h1000_1104, 1'b0, 3'b100, 32'h0, 0, 1'b0);
    txn(32'h1000_2206, 1'b0, 3'b101, 32'h0, 0, 1'b0);
    idle_cycles(2);

    // Reset in the middle of ACCESS aborts the transfer with no completion.
    new_words();
    bus.busReq   = 1'b1;
    bus.busWe    = 1'b0;
    bus.strb     = 3'b010;
    bus.busAddr  = 32'h1000_1000;
    drive_slaves(1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive_slaves(1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_penable", bus.penable, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_psel", bus.psel, '0);
    check("abort_penable", bus.penable, 1'b0);
    check("abort_paddr", bus.paddr, '0);
    check("abort_busReady", bus.busReady, 1'b0);
    check("abort_busRData", bus.busRData, '0);
    bus.busReq = 1'b0;
    @(negedge clk) reset = 1'b1;
    idle_cycles(3);
    txn(32'h1000_1000, 1'b0, 3'b010, 32'h0, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      new_words();
      r = $urandom_range(0, 7);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = BASE_ADDR - 32'($urandom_range(1, 16));
      else addr = BASE_ADDR + 32'($urandom_range(0, (NUM_SLAVES + 1) * (1 << REGION_BITS) - 1));
      r = $urandom_range(0, 11);
      if (r < 8)       waits = r % 4;
      else if (r == 8) waits = TIMEOUT - 1;
      else if (r == 9) waits = TIMEOUT;
      else             waits = 40;
      txn(addr, 1'($urandom), 3'($urandom), $urandom, waits, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
